wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, the number of consecutive cycles the coprocessor FIFO may wait while non-empty before stall_req asserts.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  global clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pipe_valid  in  1  in-order pipeline writeback valid
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  BITS  pipeline result
- cop_valid  in  1  coprocessor/long-latency result valid
- cop_ready  out  1  coprocessor result accepted when high with cop_valid
- cop_rd  in  5  coprocessor destination register
- cop_data  in  BITS  coprocessor result
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  destination of the issued op
- sr1, sr2  in  5  decode source addresses for hazard lookup
- sr1_pending, sr2_pending  out  1  source has an outstanding long-latency write
- stall_req  out  1  registered request for the pipeline to insert a bubble next cycle
- err_waw  out  1  sticky protocol-error flag
- wb_wen, wb_rd, wb_data  out  1/5/BITS  register-file write port (WEN, RD, DEST_DATA)

Function
REQ-003 wb_wen/wb_rd/wb_data SHALL be registered, one cycle after selection, so they are stable at the register file's falling-edge write.
REQ-004 A pipe write SHALL be selected when pipe_valid=1 and pipe_rd!=0; the pipe source SHALL always win and SHALL never be back-pressured.
REQ-005 Coprocessor results SHALL enter a 2-entry FIFO; cop_ready SHALL equal FIFO not full, combinationally from current occupancy.
REQ-006 The FIFO head SHALL be selected in any cycle with no pipe write selected; pop and push in the same cycle SHALL be legal at any occupancy except push when full.
REQ-007 When the FIFO is full, a push and a pop in the same cycle SHALL NOT happen, because cop_ready is low; occupancy SHALL stay 2 until a pop.
REQ-008 A FIFO entry with rd=0 SHALL be popped with wb_wen=0.
REQ-009 The FIFO SHALL use wrapping 1-bit read/write pointers with a 2-bit count.
REQ-010 When no source is selected, the output register SHALL load wb_wen=0; wb_rd and wb_data SHALL hold their values.
REQ-011 The starvation counter SHALL increment each cycle the FIFO is non-empty and the pipe wins, and SHALL clear on any pop or when the FIFO is empty.
REQ-012 stall_req SHALL be registered and SHALL be high the cycle after the starvation counter reaches STARVE_MAX or the FIFO becomes full; it SHALL drop the cycle after a pop.
REQ-013 The scoreboard is a 32-bit pending bitmap; bit 0 SHALL never be set.
REQ-014 issue_valid with issue_rd!=0 SHALL set bit issue_rd; a FIFO pop SHALL clear the popped rd bit; if both target the same register in one cycle, set SHALL win.
REQ-015 sr1_pending/sr2_pending SHALL be combinational bitmap lookups; a register cleared this cycle SHALL still read pending this cycle.
REQ-016 A selected pipe write whose rd is pending SHALL still be performed and SHALL set err_waw until reset.

Reset
REQ-017 While rst_n=0 at a rising edge, the block SHALL clear the FIFO, pointers, count, starvation counter, bitmap, err_waw, stall_req, wb_wen, wb_rd and wb_data.
REQ-018 cop_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-019 Reset mid-operation SHALL discard buffered results without writing them back.

Configuration
REQ-020 With macro WB_SCOREBOARD_EN defined, REQ-013 to REQ-016 SHALL apply.
REQ-021 Without WB_SCOREBOARD_EN, there SHALL be no bitmap; sr1_pending, sr2_pending and err_waw SHALL be tied 0; issue_valid and issue_rd SHALL be ignored.

Structure
REQ-022 BITS SHALL come from common_params; the FIFO entry struct (rd, data) and the STARVE_MAX default SHALL be added to that package.
REQ-023 The 2-entry FIFO SHALL be a sub-module named wb_fifo2.

Verification
REQ-024 Reset, then cop push rd=5 data=0xA5A5A5A5 with pipe idle -> two cycles later wb_wen=1, wb_rd=5, wb_data=0xA5A5A5A5.
REQ-025 pipe_rd=3 each cycle for 6 cycles with the FIFO holding rd=7 -> pipe writes appear in order; stall_req=1 after 4 waiting cycles; rd=7 is written in the first pipe-idle cycle.
REQ-026 Three back-to-back cop pushes with the pipe busy -> cop_ready=0 after the second push; the third is held until a pop.
REQ-027 issue rd=9, then sr1=9 -> sr1_pending=1 until the cycle after the rd=9 pop; issue and pop of rd=9 in the same cycle -> stays pending.
REQ-028 pipe write rd=9 while rd=9 is pending -> err_waw=1 until reset; without WB_SCOREBOARD_EN, err_waw stays 0.
REQ-029 pipe_rd=0 and cop rd=0 -> wb_wen never asserts; rst_n=0 with 2 entries buffered -> no write occurs.

Source files
------------

// File: rtl/common_params.sv
// Shared widths and types for the writeback datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package common_params;

  // Register-file data width
  localparam int BITS = 32;

  // Register address width (32 architectural registers)
  localparam int RD_W = 5;

  // Default number of cycles a non-empty coprocessor FIFO may be starved
  localparam int STARVE_MAX_DEF = 4;

  // One buffered coprocessor result
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [BITS-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO holding coprocessor results awaiting a writeback slot.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full is exposed to the caller; pushes while full and pops while empty are ignored.
module wb_fifo2
  import common_params::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_dat,
  input  logic      pop,
  output wb_entry_t head_dat,
  output logic      empty,
  output logic      full
);

  wb_entry_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push_ok;
  logic       pop_ok;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy; reset drops anything buffered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline and coprocessor writebacks onto one register-file write port (optional scoreboard: WB_SCOREBOARD_EN).
// Latency: write port is registered one cycle after selection; coprocessor results wait at least one cycle in the FIFO.
// Backpressure: pipeline never stalled here; cop_ready drops when the 2-entry FIFO is full, stall_req asks for a bubble.
module wb_arbiter
  import common_params::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid,
  input  logic [RD_W-1:0] pipe_rd,
  input  logic [BITS-1:0] pipe_data,
  input  logic            cop_valid,
  output logic            cop_ready,
  input  logic [RD_W-1:0] cop_rd,
  input  logic [BITS-1:0] cop_data,
  input  logic            issue_valid,
  input  logic [RD_W-1:0] issue_rd,
  input  logic [RD_W-1:0] sr1,
  input  logic [RD_W-1:0] sr2,
  output logic            sr1_pending,
  output logic            sr2_pending,
  output logic            stall_req,
  output logic            err_waw,
  output logic            wb_wen,
  output logic [RD_W-1:0] wb_rd,
  output logic [BITS-1:0] wb_data
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic             pipe_sel;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  wb_entry_t        push_dat;
  wb_entry_t        head_dat;
  logic [CNT_W-1:0] starve_cnt;

  // Pipe always wins; the FIFO head only drains in slots the pipe leaves free
  assign pipe_sel  = pipe_valid && (pipe_rd != '0);
  assign cop_ready = !fifo_full;
  assign push      = cop_valid && cop_ready;
  assign pop       = !fifo_empty && !pipe_sel;
  assign push_dat  = '{rd: cop_rd, data: cop_data};

  wb_fifo2 u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Registered write port; rd=0 entries drain silently, idle cycles hold rd/data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_wen  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (pipe_sel) begin
      wb_wen  <= 1'b1;
      wb_rd   <= pipe_rd;
      wb_data <= pipe_data;
    end else if (pop) begin
      wb_wen  <= (head_dat.rd != '0);
      wb_rd   <= head_dat.rd;
      wb_data <= head_dat.data;
    end else begin
      wb_wen  <= 1'b0;
    end
  end

  // Count consecutive cycles the FIFO waits behind the pipe, saturating at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (pipe_sel && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Ask for a bubble once starved or full; any drain releases it next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_req <= 1'b0;
    end else begin
      stall_req <= !pop && ((starve_cnt == CNT_MAX) || fifo_full);
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pend;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Bitmap updates: issue sets, drain clears, set wins on the same register
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_rd != '0)) begin
      set_mask[issue_rd] = 1'b1;
    end
    if (pop) begin
      clr_mask[head_dat.rd] = 1'b1;
    end
  end

  // Pending bitmap; register 0 is hardwired and never tracked
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= ((pend & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  // Sticky flag: pipeline overwrote a register still owed by the coprocessor
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_waw <= 1'b0;
    end else if (pipe_sel && pend[pipe_rd]) begin
      err_waw <= 1'b1;
    end
  end

  // Lookups read the pre-update bitmap, so a same-cycle clear still reads pending
  assign sr1_pending = pend[sr1];
  assign sr2_pending = pend[sr2];
`else
  logic unused_sb;

  assign sr1_pending = 1'b0;
  assign sr2_pending = 1'b0;
  assign err_waw     = 1'b0;
  assign unused_sb   = ^{issue_valid, issue_rd, sr1, sr2};
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed checks of the writeback arbiter.
// Latency: drives inputs 1ns after each rising edge and samples there.
// Backpressure: follows cop_ready by construction of the vectors.
module tb_wb_arbiter;
  import common_params::*;

`ifdef WB_SCOREBOARD_EN
  localparam logic [31:0] SB = 32'd1;
`else
  localparam logic [31:0] SB = 32'd0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pipe_valid;
  logic [RD_W-1:0] pipe_rd;
  logic [BITS-1:0] pipe_data;
  logic            cop_valid;
  logic            cop_ready;
  logic [RD_W-1:0] cop_rd;
  logic [BITS-1:0] cop_data;
  logic            issue_valid;
  logic [RD_W-1:0] issue_rd;
  logic [RD_W-1:0] sr1;
  logic [RD_W-1:0] sr2;
  logic            sr1_pending;
  logic            sr2_pending;
  logic            stall_req;
  logic            err_waw;
  logic            wb_wen;
  logic [RD_W-1:0] wb_rd;
  logic [BITS-1:0] wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_valid  (pipe_valid),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .cop_valid   (cop_valid),
    .cop_ready   (cop_ready),
    .cop_rd      (cop_rd),
    .cop_data    (cop_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .sr1         (sr1),
    .sr2         (sr2),
    .sr1_pending (sr1_pending),
    .sr2_pending (sr2_pending),
    .stall_req   (stall_req),
    .err_waw     (err_waw),
    .wb_wen      (wb_wen),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    cop_valid = 1'b0; cop_rd = '0; cop_data = '0;
    issue_valid = 1'b0; issue_rd = '0; sr1 = '0; sr2 = '0;

    // Reset state
    tick(); tick();
    chk("rst_wen",   32'(wb_wen),    32'd0);
    chk("rst_rd",    32'(wb_rd),     32'd0);
    chk("rst_data",  wb_data,        32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_err",   32'(err_waw),   32'd0);
    rst_n = 1'b1;
    #1 chk("rdy_after_rst", 32'(cop_ready), 32'd1);

    // Single cop result with idle pipe: written two edges later
    cop_valid = 1'b1; cop_rd = 5'd5; cop_data = 32'hA5A5_A5A5;
    tick(); cop_valid = 1'b0;
    chk("t1_wen_early", 32'(wb_wen), 32'd0);
    tick();
    chk("t1_wen",  32'(wb_wen), 32'd1);
    chk("t1_rd",   32'(wb_rd),  32'd5);
    chk("t1_data", wb_data,     32'hA5A5_A5A5);
    tick();
    chk("t1_idle_wen",  32'(wb_wen), 32'd0);
    chk("t1_hold_rd",   32'(wb_rd),  32'd5);
    chk("t1_hold_data", wb_data,     32'hA5A5_A5A5);

    // Pipe busy six cycles while rd=7 waits; stall after four starved cycles
    cop_valid = 1'b1; cop_rd = 5'd7; cop_data = 32'h77;
    pipe_valid = 1'b1; pipe_rd = 5'd3;
    for (int i = 0; i < 6; i++) begin
      pipe_data = BITS'(32'h300 + i);
      tick(); cop_valid = 1'b0;
      chk("t2_pipe_rd",   32'(wb_rd),     32'd3);
      chk("t2_pipe_data", wb_data,        32'h300 + 32'(i));
      chk("t2_stall",     32'(stall_req), (i == 5) ? 32'd1 : 32'd0);
    end
    pipe_valid = 1'b0;
    tick();
    chk("t2_cop_wen",   32'(wb_wen),    32'd1);
    chk("t2_cop_rd",    32'(wb_rd),     32'd7);
    chk("t2_cop_data",  wb_data,        32'h77);
    chk("t2_stall_off", 32'(stall_req), 32'd0);

    // Three back-to-back pushes with pipe busy
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h400;
    cop_valid = 1'b1; cop_rd = 5'd10; cop_data = 32'h100A;
    #1 chk("t3_rdy0", 32'(cop_ready), 32'd1);
    tick(); cop_rd = 5'd11; cop_data = 32'h100B;
    chk("t3_rdy1", 32'(cop_ready), 32'd1);
    tick(); cop_rd = 5'd12; cop_data = 32'h100C;
    chk("t3_rdy_full", 32'(cop_ready), 32'd0);
    chk("t3_pipe_rd",  32'(wb_rd),     32'd4);
    tick();
    chk("t3_rdy_held",  32'(cop_ready), 32'd0);
    chk("t3_stall_full", 32'(stall_req), 32'd1);
    pipe_valid = 1'b0;
    tick();
    chk("t3_pop10_rd",   32'(wb_rd),     32'd10);
    chk("t3_pop10_data", wb_data,        32'h100A);
    chk("t3_stall_drop", 32'(stall_req), 32'd0);
    chk("t3_rdy_again",  32'(cop_ready), 32'd1);
    tick(); cop_valid = 1'b0;
    chk("t3_pop11_rd", 32'(wb_rd), 32'd11);
    tick();
    chk("t3_pop12_rd",   32'(wb_rd), 32'd12);
    chk("t3_pop12_data", wb_data,    32'h100C);
    tick();
    chk("t3_empty_wen", 32'(wb_wen), 32'd0);

    // rd=0 from both sources never writes
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hBAD;
    cop_valid = 1'b1; cop_rd = 5'd0; cop_data = 32'hDEAD;
    tick(); cop_valid = 1'b0;
    chk("t4_wen_a", 32'(wb_wen), 32'd0);
    tick(); pipe_valid = 1'b0;
    chk("t4_wen_b", 32'(wb_wen), 32'd0);
    tick();
    chk("t4_wen_c", 32'(wb_wen), 32'd0);

    // Scoreboard: issue, WAW error, clear on pop, set wins over clear
    issue_valid = 1'b1; issue_rd = 5'd9; sr1 = 5'd9; sr2 = 5'd9;
    #1 chk("t5_pre_issue", 32'(sr1_pending), 32'd0);
    tick(); issue_valid = 1'b0;
    chk("t5_sr1_pend", 32'(sr1_pending), SB);
    chk("t5_sr2_pend", 32'(sr2_pending), SB);
    chk("t5_err_clr",  32'(err_waw),     32'd0);
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h999;
    tick(); pipe_valid = 1'b0;
    chk("t5_waw_wen", 32'(wb_wen),  32'd1);
    chk("t5_waw_rd",  32'(wb_rd),   32'd9);
    chk("t5_err_set", 32'(err_waw), SB);
    cop_valid = 1'b1; cop_rd = 5'd9; cop_data = 32'h9C;
    tick(); cop_valid = 1'b0;
    chk("t5_pend_during_pop", 32'(sr1_pending), SB);
    tick();
    chk("t5_pop9_data",   wb_data,            32'h9C);
    chk("t5_pend_cleared", 32'(sr1_pending),  32'd0);
    cop_valid = 1'b1; cop_rd = 5'd9; cop_data = 32'h9D;
    tick(); cop_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
    tick(); issue_valid = 1'b0;
    chk("t5_pop9b_data", wb_data,           32'h9D);
    chk("t5_set_wins",   32'(sr1_pending),  SB);
    chk("t5_err_sticky", 32'(err_waw),      SB);

    // Reset with two entries buffered discards them
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h444;
    cop_valid = 1'b1; cop_rd = 5'd13; cop_data = 32'hD;
    tick(); cop_rd = 5'd14; cop_data = 32'hE;
    tick(); cop_valid = 1'b0;
    chk("t6_full", 32'(cop_ready), 32'd0);
    pipe_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("t6_rst_wen",   32'(wb_wen),      32'd0);
    chk("t6_rst_rdy",   32'(cop_ready),   32'd1);
    chk("t6_rst_err",   32'(err_waw),     32'd0);
    chk("t6_rst_pend",  32'(sr1_pending), 32'd0);
    chk("t6_rst_stall", 32'(stall_req),   32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_no_wb_a", 32'(wb_wen), 32'd0);
    tick();
    chk("t6_no_wb_b", 32'(wb_wen), 32'd0);
    chk("t6_rd_zero", 32'(wb_rd),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
